nonce_result_collector: RTL and testbench

Consumer end of the nonce/cycle counter pair in the SHA miner core. The block watches the round cycle count and samples the finished hash together with the nonce that produced it. Each hash is compared against the difficulty target. Winning ("golden") nonces are queued in a small FIFO and presented to the host-side controller over a valid/ready handshake.

---
 rtl/nonce_result_collector.sv | 111 +++++++++++
 tb/tb_nonce_result_collector.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/nonce_result_collector.sv
// rtl/nonce_result_collector.sv - samples finished hashes, compares to target, queues golden nonces
// Hits go into a small pointer-based FIFO; the head is presented on a valid/ready port.
module nonce_result_collector #(
  parameter int unsigned NONCE_W    = 32,
  parameter int unsigned HASH_W     = 256,
  parameter int unsigned DONE_CYCLE = 63,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               en,
  input  logic [5:0]         cycle,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [HASH_W-1:0]  hash,
  input  logic [HASH_W-1:0]  target,
  output logic               out_valid,
  output logic [NONCE_W-1:0] out_nonce,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   found_count,
  output logic               overflow,
  output logic               exhausted
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;
  localparam logic [5:0]       DONE_CYC = 6'(DONE_CYCLE);
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NONCE_W-1:0] mem_q [DEPTH];
  logic [NONCE_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   found_count_q, found_count_d;
  logic               overflow_q, overflow_d;
  logic               exhausted_q, exhausted_d;

  logic fifo_empty;
  logic fifo_full;
  logic sample;
  logic hit;
  logic pop;
  logic push;
  logic drop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign sample = en && (cycle == DONE_CYC) && !exhausted_q;
  assign hit    = sample && (hash < target);
  assign pop    = !fifo_empty && out_ready;
  assign push   = hit && (!fifo_full || pop);
  assign drop   = hit && fifo_full && !pop;

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    found_count_d = found_count_q;
    overflow_d    = overflow_q;
    exhausted_d   = exhausted_q;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = nonce;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
    if (hit && (found_count_q != {CNT_W{1'b1}})) begin
      found_count_d = found_count_q + CNT_ONE;
    end
    if (sample && (&nonce)) begin
      exhausted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      found_count_q <= '0;
      overflow_q    <= 1'b0;
      exhausted_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      found_count_q <= found_count_d;
      overflow_q    <= overflow_d;
      exhausted_q   <= exhausted_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid   = !fifo_empty;
  assign out_nonce   = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign found_count = found_count_q;
  assign overflow    = overflow_q;
  assign exhausted   = exhausted_q;

endmodule

// File: tb/tb_nonce_result_collector.sv
// tb/tb_nonce_result_collector.sv - directed vector table plus randomized run against a queue model
module tb_nonce_result_collector;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         clear;
  logic         en;
  logic [5:0]   cycle;
  logic [31:0]  nonce;
  logic [255:0] hash;
  logic [255:0] target;
  logic         out_valid;
  logic [31:0]  out_nonce;
  logic         out_ready;
  logic [15:0]  found_count;
  logic         overflow;
  logic         exhausted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nonce_result_collector dut (
    .clk        (clk),
    .clear      (clear),
    .en         (en),
    .cycle      (cycle),
    .nonce      (nonce),
    .hash       (hash),
    .target     (target),
    .out_valid  (out_valid),
    .out_nonce  (out_nonce),
    .out_ready  (out_ready),
    .found_count(found_count),
    .overflow   (overflow),
    .exhausted  (exhausted)
  );

  typedef struct {
    logic         clr;
    logic         en;
    logic [5:0]   cyc;
    logic [31:0]  nonce;
    logic [255:0] hash;
    logic         ready;
    logic         ev;
    logic [31:0]  enonce;
    logic [15:0]  ecnt;
    logic         eovf;
    logic         eexh;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: a queue of golden nonces plus the three status values.
  logic [31:0] m_q[$];
  int          m_found;
  bit          m_ovf;
  bit          m_exh;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit c, input bit e, input int cy, input logic [31:0] n,
                     input logic [255:0] h, input bit r, input bit ev,
                     input logic [31:0] en_, input int ec, input bit eo, input bit ex);
    vec_t v;
    v.clr = c; v.en = e; v.cyc = 6'(cy); v.nonce = n; v.hash = h; v.ready = r;
    v.ev = ev; v.enonce = en_; v.ecnt = 16'(ec); v.eovf = eo; v.eexh = ex;
    tbl.push_back(v);
  endtask

  task automatic drive(input bit c, input bit e, input logic [5:0] cy, input logic [31:0] n,
                       input logic [255:0] h, input bit r);
    @(negedge clk);
    clear = c; en = e; cycle = cy; nonce = n; hash = h; out_ready = r;
  endtask

  task automatic model_step;
    bit pop;
    bit samp;
    bit win;
    if (clear) begin
      m_q.delete();
      m_found = 0; m_ovf = 0; m_exh = 0;
    end else begin
      pop  = (m_q.size() != 0) && out_ready;
      samp = en && (cycle == 6'd63) && !m_exh;
      win  = samp && (hash < target);
      if (pop) void'(m_q.pop_front());
      if (win) begin
        if (m_found < 65535) m_found++;
        if (m_q.size() < DEPTH) m_q.push_back(nonce);
        else m_ovf = 1;
      end
      if (samp && nonce == 32'hFFFF_FFFF) m_exh = 1;
    end
  endtask

  initial begin
    logic [255:0] tgt;
    logic [255:0] win_h;
    logic [255:0] eq_h;
    tgt   = 256'd1 << 240;
    win_h = 256'd1 << 239;
    eq_h  = 256'd1 << 240;
    target = tgt;
    clear = 1'b1; en = 1'b1; cycle = 6'd63; nonce = 32'h0; hash = win_h; out_ready = 1'b0;

    //  clr en cyc nonce         hash   rdy  ev  enonce        cnt ovf exh
    add(1, 1, 63, 32'hDEAD,      win_h, 1,   0, 32'h0,         0, 0, 0);
    add(1, 0, 12, 32'hBEEF,      eq_h,  0,   0, 32'h0,         0, 0, 0);
    add(0, 1, 63, 32'h1234,      win_h, 0,   1, 32'h1234,      1, 0, 0);
    add(0, 1, 63, 32'h5555,      eq_h,  0,   1, 32'h1234,      1, 0, 0);
    add(0, 1, 62, 32'h0077,      win_h, 0,   1, 32'h1234,      1, 0, 0);
    add(0, 0, 63, 32'h0078,      win_h, 0,   1, 32'h1234,      1, 0, 0);
    add(0, 1, 0,  32'h0000,      win_h, 1,   0, 32'h0,         1, 0, 0);
    for (int i = 1; i <= 4; i++)
      add(0, 1, 63, 32'(i),      win_h, 0,   1, 32'h1,         1 + i, 0, 0);
    add(0, 1, 63, 32'h5,         win_h, 0,   1, 32'h1,         6, 1, 0);
    for (int i = 2; i <= 4; i++)
      add(0, 1, 0,  32'h0,       win_h, 1,   1, 32'(i),        6, 1, 0);
    add(0, 1, 0,  32'h0,         win_h, 1,   0, 32'h0,         6, 1, 0);
    add(1, 1, 63, 32'h6,         win_h, 1,   0, 32'h0,         0, 0, 0);
    for (int i = 1; i <= 4; i++)
      add(0, 1, 63, 32'(i),      win_h, 0,   1, 32'h1,         i, 0, 0);
    add(0, 1, 63, 32'h9,         win_h, 1,   1, 32'h2,         5, 0, 0);
    add(0, 1, 0,  32'h0,         win_h, 1,   1, 32'h3,         5, 0, 0);
    add(0, 1, 0,  32'h0,         win_h, 1,   1, 32'h4,         5, 0, 0);
    add(0, 1, 0,  32'h0,         win_h, 1,   1, 32'h9,         5, 0, 0);
    add(0, 1, 0,  32'h0,         win_h, 1,   0, 32'h0,         5, 0, 0);
    add(0, 1, 63, 32'hFFFF_FFFF, win_h, 0,   1, 32'hFFFF_FFFF, 6, 0, 1);
    add(0, 1, 63, 32'h0,         win_h, 0,   1, 32'hFFFF_FFFF, 6, 0, 1);
    add(1, 1, 63, 32'h0,         win_h, 0,   0, 32'h0,         0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].en, tbl[i].cyc, tbl[i].nonce, tbl[i].hash, tbl[i].ready);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i),   64'(out_valid),   64'(tbl[i].ev));
      chk($sformatf("vec%0d out_nonce", i),   64'(out_nonce),   64'(tbl[i].enonce));
      chk($sformatf("vec%0d found_count", i), 64'(found_count), 64'(tbl[i].ecnt));
      chk($sformatf("vec%0d overflow", i),    64'(overflow),    64'(tbl[i].eovf));
      chk($sformatf("vec%0d exhausted", i),   64'(exhausted),   64'(tbl[i].eexh));
    end

    // Random phase: model starts from the clear applied by the last vector.
    m_q.delete(); m_found = 0; m_ovf = 0; m_exh = 0;
    target = {8'h80, 248'h0};
    for (int t = 0; t < 3000; t++) begin
      logic [255:0] h;
      logic [31:0]  n;
      logic [5:0]   cy;
      for (int w = 0; w < 8; w++) h[w*32 +: 32] = $urandom;
      if ($urandom_range(0, 15) == 0) h = target;
      n  = ($urandom_range(0, 150) == 0) ? 32'hFFFF_FFFF : $urandom;
      cy = ($urandom_range(0, 1) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
      drive($urandom_range(0, 250) == 0, $urandom_range(0, 9) != 0, cy, n, h,
            $urandom_range(0, 2) == 0);
      model_step();
      @(posedge clk);
      #1;
      chk("rnd out_valid",   64'(out_valid),   64'(m_q.size() != 0));
      chk("rnd out_nonce",   64'(out_nonce),   64'((m_q.size() != 0) ? m_q[0] : 32'h0));
      chk("rnd found_count", 64'(found_count), 64'(m_found));
      chk("rnd overflow",    64'(overflow),    64'(m_ovf));
      chk("rnd exhausted",   64'(exhausted),   64'(m_exh));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
